mem_port_arbiter: RTL and testbench

//  Shares the single unified instruction/data memory port between the multicycle core
//  (fetch/load/store) and a second master (debug/DMA loader). Round-robin arbitration,
//  one outstanding transaction, variable-latency memory via req/ack, watchdog timeout.

---
 rtl/mem_port_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one unified instruction/data memory port between the core (c_*) and a second master (d_*).
// Latency: request seen in IDLE -> m_req next cycle; m_ack at cycle k -> x_ready at k+1 (min 2 cycles).
// Backpressure: one transaction in flight; requesters hold x_req until their x_ready pulse, then drop it.
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-low reset
//   c_req/c_we/c_addr/c_wdata -> c_ready/c_rdata   core master
//   d_req/d_we/d_addr/d_wdata -> d_ready/d_rdata   debug/DMA master
//   m_req/m_we/m_addr/m_wdata <- m_ack/m_rdata      memory side
//   grant                one-hot owner {d,c}, 00 while idle
//   err                  pulses with x_ready when the watchdog ended the transaction
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,

  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_ready,
  output logic [DW-1:0] c_rdata,

  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ready,
  output logic [DW-1:0] d_rdata,

  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic          m_ack,
  input  logic [DW-1:0] m_rdata,

  output logic [1:0]    grant,
  output logic          err
);

  // Watchdog counter sized to hold TIMEOUT; a disabled watchdog still keeps a 1-bit counter.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit WD_EN = (TIMEOUT > 0);
  localparam logic [CW-1:0] CNT_LAST = WD_EN ? CW'(TIMEOUT - 1) : '0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          last_d_q;          // 1 = the debug master won the previous arbitration
  logic [1:0]    grant_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [CW-1:0] cnt_q;
  logic          err_q;
  logic [DW-1:0] c_rdata_q;
  logic [DW-1:0] d_rdata_q;

  // Arbitration: a lone requester wins; on a tie the master that did not win last time wins.
  logic any_req;
  logic pick_d;
  assign any_req = c_req | d_req;
  assign pick_d  = d_req & (~c_req | ~last_d_q);

  // Watchdog fires on the last permitted BUSY cycle, but only when no ack arrives with it.
  logic wd_fire;
  logic cnt_sat;
  assign wd_fire = WD_EN && (cnt_q == CNT_LAST) && !m_ack;
  assign cnt_sat = &cnt_q;

  // Writes return zero data; reads return the memory data sampled with the ack.
  logic [DW-1:0] rsp_data;
  assign rsp_data = we_q ? '0 : m_rdata;

  logic busy_done;
  assign busy_done = (state_q == ST_BUSY) && (m_ack || wd_fire);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (any_req)   state_d = ST_BUSY;
      ST_BUSY: if (busy_done) state_d = ST_RESP;
      ST_RESP:                state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Winner capture: owner, command and the fairness pointer are latched only when leaving IDLE,
  // so requester inputs have no effect for the rest of the transaction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_d_q <= 1'b1;  // pretend the debug master won last, so the first tie goes to the core
      grant_q  <= 2'b00;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            last_d_q <= pick_d;
            grant_q  <= pick_d ? 2'b10 : 2'b01;
            we_q     <= pick_d ? d_we    : c_we;
            addr_q   <= pick_d ? d_addr  : c_addr;
            wdata_q  <= pick_d ? d_wdata : c_wdata;
          end
        end
        ST_RESP: grant_q <= 2'b00;
        default: ;
      endcase
    end
  end

  // Watchdog counter: counts BUSY cycles, saturating, and is cleared outside BUSY.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (state_q == ST_BUSY) begin
      if (!cnt_sat) cnt_q <= cnt_q + CW'(1);
    end else begin
      cnt_q <= '0;
    end
  end

  // Completion status and per-master read data. The read-data registers hold their value
  // between transactions; they are only meaningful while the matching ready is high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q     <= 1'b0;
      c_rdata_q <= '0;
      d_rdata_q <= '0;
    end else if (busy_done) begin
      // An ack in the watchdog's last cycle still counts as a normal completion.
      err_q <= !m_ack;
      if (grant_q[0]) c_rdata_q <= m_ack ? rsp_data : '0;
      if (grant_q[1]) d_rdata_q <= m_ack ? rsp_data : '0;
    end else if (state_q == ST_IDLE) begin
      err_q <= 1'b0;
    end
  end

  // m_req comes straight from state so it drops the moment reset is asserted.
  assign m_req   = (state_q == ST_BUSY);
  assign m_we    = we_q;
  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;

  assign grant   = grant_q;
  assign c_ready = (state_q == ST_RESP) && grant_q[0];
  assign d_ready = (state_q == ST_RESP) && grant_q[1];
  assign err     = (state_q == ST_RESP) && err_q;
  assign c_rdata = c_rdata_q;
  assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: per-cycle vector table plus directed multi-cycle sequences.
// Latency: each vector's expected outputs are sampled 1ns after the rising edge that consumes its inputs.
// Backpressure: requesters follow the hold-until-ready protocol; memory ack is driven per vector.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          c_req = 1'b0, c_we = 1'b0;
  logic [AW-1:0] c_addr = '0;
  logic [DW-1:0] c_wdata = '0;
  logic          c_ready;
  logic [DW-1:0] c_rdata;
  logic          d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_ready;
  logic [DW-1:0] d_rdata;
  logic          m_req, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_ack = 1'b0;
  logic [DW-1:0] m_rdata = '0;
  logic [1:0]    grant;
  logic          err;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_ready(c_ready), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata),
    .grant(grant), .err(err)
  );

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        c_req, c_we;
    logic [31:0] c_addr, c_wdata;
    logic        d_req, d_we;
    logic [31:0] d_addr, d_wdata;
    logic        m_ack;
    logic [31:0] m_rdata;
    logic        e_m_req, e_m_we;
    logic [31:0] e_m_addr, e_m_wdata;
    logic [1:0]  e_grant;
    logic        e_c_ready, e_d_ready;
    logic [31:0] e_c_rdata, e_d_rdata;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(
    input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
    input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd,
    input logic ak, input logic [31:0] rd,
    input logic emr, input logic emw, input logic [31:0] ema, input logic [31:0] emd,
    input logic [1:0] eg, input logic ecr, input logic edr,
    input logic [31:0] ecd, input logic [31:0] edd, input logic ee);
    vec_t v;
    v.c_req = cr; v.c_we = cw; v.c_addr = ca; v.c_wdata = cd;
    v.d_req = dr; v.d_we = dw; v.d_addr = da; v.d_wdata = dd;
    v.m_ack = ak; v.m_rdata = rd;
    v.e_m_req = emr; v.e_m_we = emw; v.e_m_addr = ema; v.e_m_wdata = emd;
    v.e_grant = eg; v.e_c_ready = ecr; v.e_d_ready = edr;
    v.e_c_rdata = ecd; v.e_d_rdata = edd; v.e_err = ee;
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    m_ack = 0; m_rdata = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL global time limit: got running expected finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int n;

    // Round-robin with both masters holding requests: c, d, c, d.
    add_vec(1,0,32'h10,32'hC0, 1,0,32'h20,32'hD0, 0,32'h0,        1,0,32'h10,32'hC0, 2'b01,0,0, 32'h0, 32'h0, 0);
    add_vec(1,0,32'h10,32'hC0, 1,0,32'h20,32'hD0, 1,32'h11,       0,0,32'h10,32'hC0, 2'b01,1,0, 32'h11,32'h0, 0);
    add_vec(1,0,32'h10,32'hC0, 1,0,32'h20,32'hD0, 0,32'h0,        0,0,32'h10,32'hC0, 2'b00,0,0, 32'h11,32'h0, 0);
    add_vec(1,0,32'h10,32'hC0, 1,0,32'h20,32'hD0, 0,32'h0,        1,0,32'h20,32'hD0, 2'b10,0,0, 32'h11,32'h0, 0);
    add_vec(1,0,32'h10,32'hC0, 1,0,32'h20,32'hD0, 1,32'h22,       0,0,32'h20,32'hD0, 2'b10,0,1, 32'h11,32'h22,0);
    add_vec(1,0,32'h10,32'hC0, 1,0,32'h20,32'hD0, 0,32'h0,        0,0,32'h20,32'hD0, 2'b00,0,0, 32'h11,32'h22,0);
    add_vec(1,0,32'h10,32'hC0, 1,0,32'h20,32'hD0, 0,32'h0,        1,0,32'h10,32'hC0, 2'b01,0,0, 32'h11,32'h22,0);
    add_vec(1,0,32'h10,32'hC0, 1,0,32'h20,32'hD0, 1,32'h33,       0,0,32'h10,32'hC0, 2'b01,1,0, 32'h33,32'h22,0);
    add_vec(1,0,32'h10,32'hC0, 1,0,32'h20,32'hD0, 0,32'h0,        0,0,32'h10,32'hC0, 2'b00,0,0, 32'h33,32'h22,0);
    add_vec(1,0,32'h10,32'hC0, 1,0,32'h20,32'hD0, 0,32'h0,        1,0,32'h20,32'hD0, 2'b10,0,0, 32'h33,32'h22,0);
    add_vec(1,0,32'h10,32'hC0, 1,0,32'h20,32'hD0, 1,32'h44,       0,0,32'h20,32'hD0, 2'b10,0,1, 32'h33,32'h44,0);
    add_vec(0,0,32'h0, 32'h0,  0,0,32'h0, 32'h0,  0,32'h0,        0,0,32'h20,32'hD0, 2'b00,0,0, 32'h33,32'h44,0);
    // Core read alone, ack in the first BUSY cycle.
    add_vec(1,0,32'h100,32'h0, 0,0,32'h0,32'h0, 0,32'h0,          1,0,32'h100,32'h0, 2'b01,0,0, 32'h33,32'h44,0);
    add_vec(1,0,32'h100,32'h0, 0,0,32'h0,32'h0, 1,32'hCAFEF00D,   0,0,32'h100,32'h0, 2'b01,1,0, 32'hCAFEF00D,32'h44,0);
    add_vec(0,0,32'h0,  32'h0, 0,0,32'h0,32'h0, 0,32'h0,          0,0,32'h100,32'h0, 2'b00,0,0, 32'hCAFEF00D,32'h44,0);
    // Debug write, ack on the fifth BUSY cycle; requester inputs wiggle and must be ignored.
    add_vec(0,0,32'h0,  32'h0, 1,1,32'h20,32'h55, 0,32'h0,        1,1,32'h20,32'h55, 2'b10,0,0, 32'hCAFEF00D,32'h44,0);
    for (int i = 0; i < 4; i++)
      add_vec(1,1,32'h999,32'h77, 1,0,32'hFFF,32'hAA, 0,32'h0,    1,1,32'h20,32'h55, 2'b10,0,0, 32'hCAFEF00D,32'h44,0);
    add_vec(0,0,32'h0,  32'h0, 1,1,32'h20,32'h55, 1,32'h1234,     0,1,32'h20,32'h55, 2'b10,0,1, 32'hCAFEF00D,32'h0,0);
    add_vec(0,0,32'h0,  32'h0, 0,0,32'h0, 32'h0,  0,32'h0,        0,1,32'h20,32'h55, 2'b00,0,0, 32'hCAFEF00D,32'h0,0);

    // Reset state, with a request pending that must not be granted.
    c_req = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst m_req",   32'(m_req),   32'd0);
    check("rst m_we",    32'(m_we),    32'd0);
    check("rst m_addr",  m_addr,       32'd0);
    check("rst m_wdata", m_wdata,      32'd0);
    check("rst grant",   32'(grant),   32'd0);
    check("rst c_ready", 32'(c_ready), 32'd0);
    check("rst d_ready", 32'(d_ready), 32'd0);
    check("rst c_rdata", c_rdata,      32'd0);
    check("rst d_rdata", d_rdata,      32'd0);
    check("rst err",     32'(err),     32'd0);
    c_req = 0;
    @(negedge clk);
    reset = 1;

    foreach (vecs[i]) begin
      c_req = vecs[i].c_req; c_we = vecs[i].c_we; c_addr = vecs[i].c_addr; c_wdata = vecs[i].c_wdata;
      d_req = vecs[i].d_req; d_we = vecs[i].d_we; d_addr = vecs[i].d_addr; d_wdata = vecs[i].d_wdata;
      m_ack = vecs[i].m_ack; m_rdata = vecs[i].m_rdata;
      step();
      check($sformatf("v%0d m_req", i),   32'(m_req),   32'(vecs[i].e_m_req));
      check($sformatf("v%0d m_we", i),    32'(m_we),    32'(vecs[i].e_m_we));
      check($sformatf("v%0d m_addr", i),  m_addr,       vecs[i].e_m_addr);
      check($sformatf("v%0d m_wdata", i), m_wdata,      vecs[i].e_m_wdata);
      check($sformatf("v%0d grant", i),   32'(grant),   32'(vecs[i].e_grant));
      check($sformatf("v%0d c_ready", i), 32'(c_ready), 32'(vecs[i].e_c_ready));
      check($sformatf("v%0d d_ready", i), 32'(d_ready), 32'(vecs[i].e_d_ready));
      check($sformatf("v%0d c_rdata", i), c_rdata,      vecs[i].e_c_rdata);
      check($sformatf("v%0d d_rdata", i), d_rdata,      vecs[i].e_d_rdata);
      check($sformatf("v%0d err", i),     32'(err),     32'(vecs[i].e_err));
    end
    idle_inputs();

    // Watchdog: no ack -> 16 BUSY cycles, then error completion with zero data.
    c_req = 1; c_addr = 32'h300;
    step();
    check("t4 grant", 32'(grant), 32'b01);
    n = 0;
    while (m_req === 1'b1 && n < 40) begin
      step();
      n++;
    end
    check("t4 busy cycles", n,            32'd16);
    check("t4 c_ready",     32'(c_ready), 32'd1);
    check("t4 d_ready",     32'(d_ready), 32'd0);
    check("t4 err",         32'(err),     32'd1);
    check("t4 c_rdata",     c_rdata,      32'd0);
    c_req = 0; m_ack = 1; m_rdata = 32'hBAD0BAD0;
    step();
    check("t4 idle grant",  32'(grant),   32'd0);
    check("t4 idle c_ready",32'(c_ready), 32'd0);
    check("t4 idle err",    32'(err),     32'd0);
    step();
    check("t4 late ack m_req", 32'(m_req),   32'd0);
    check("t4 late ack grant", 32'(grant),   32'd0);
    check("t4 late ack c_rdata", c_rdata,    32'd0);
    idle_inputs();

    // Ack arriving in the watchdog's final cycle wins.
    c_req = 1; c_addr = 32'h400;
    step();
    repeat (15) step();
    check("t5 still busy", 32'(m_req), 32'd1);
    m_ack = 1; m_rdata = 32'h5A5A5A5A;
    step();
    check("t5 c_ready", 32'(c_ready), 32'd1);
    check("t5 err",     32'(err),     32'd0);
    check("t5 c_rdata", c_rdata,      32'h5A5A5A5A);
    idle_inputs();
    step();

    // Reset mid-BUSY: outputs drop at once; afterwards a tie goes to the core again.
    c_req = 1; c_addr = 32'h500;
    step();
    check("t6 grant before", 32'(grant), 32'b01);
    d_req = 1; d_addr = 32'h600;
    #2;
    reset = 0;
    #1;
    check("t6 rst grant",   32'(grant),   32'd0);
    check("t6 rst m_req",   32'(m_req),   32'd0);
    check("t6 rst c_ready", 32'(c_ready), 32'd0);
    check("t6 rst m_addr",  m_addr,       32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1;
    step();
    check("t6 tie grant",   32'(grant),   32'b01);
    check("t6 tie m_addr",  m_addr,       32'h500);
    check("t6 no ready",    32'(c_ready), 32'd0);
    m_ack = 1; m_rdata = 32'h66;
    step();
    check("t6 c_ready",     32'(c_ready), 32'd1);
    check("t6 d_ready",     32'(d_ready), 32'd0);
    check("t6 c_rdata",     c_rdata,      32'h66);
    idle_inputs();
    step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
